// File: rtl/router_pkg.sv
// router_pkg: state encoding and header layout shared by the
// router output-side reader and its parity checker.
package router_pkg;

    localparam int LEN_MSB        = 7;
    localparam int LEN_LSB        = 2;
    localparam int ADDR_W         = 2;
    localparam int ROUTER_TIMEOUT = 29;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_HDR,
        S_HDR_CAP,
        S_PAYLOAD,
        S_DRAIN
    } rd_state_t;

    // Reads still owed after the header: L payload bytes plus parity.
    function automatic logic [6:0] hdr_reads(
        input logic [LEN_MSB:LEN_LSB] len
    );
        return {1'b0, len} + 7'd1;
    endfunction

endpackage

// File: rtl/router_rd_parity.sv
// router_rd_parity: running XOR over header and payload, compared
// against the trailing parity byte when it appears.
module router_rd_parity
    import router_pkg::*;
(
    input  logic       clk,
    input  logic       resetn,
    input  logic       sop,
    input  logic       byte_vld,
    input  logic       eop,
    input  logic [7:0] data,
    output logic       parity_err
);

    logic [7:0] acc;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            acc <= 8'h00;
        end else if (byte_vld) begin
            acc <= sop ? data : (acc ^ data);
        end
    end

    assign parity_err = eop && (acc != data);

endmodule

// File: rtl/router_out_reader.sv
// router_out_reader: drains one packet at a time from the router output
// FIFO. Define ROUTER_RD_PARITY_CHECK_EN to enable the parity checker.
module router_out_reader
    import router_pkg::*;
#(
    parameter int RD_DELAY = 0
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       vld_out,
    input  logic [7:0] data_out,
    input  logic       soft_reset,
    input  logic       ready,
    output logic       read_enb,
    output logic [7:0] pkt_data,
    output logic       pkt_valid,
    output logic       pkt_sop,
    output logic       pkt_eop,
    output logic       parity_err,
    output logic       pkt_abort,
    output logic [7:0] pkt_count,
    output logic       busy
);

    localparam logic [4:0] WAIT_LOAD =
        (RD_DELAY > 0) ? 5'(RD_DELAY - 1) : 5'd0;

    rd_state_t  state;
    rd_state_t  state_nxt;
    logic [6:0] remaining;
    logic [6:0] remaining_nxt;
    logic [4:0] wait_cnt;
    logic [4:0] wait_cnt_nxt;
    logic       flush;

    assign flush    = soft_reset && (state != S_IDLE);
    assign busy     = (state != S_IDLE);
    assign pkt_data = pkt_valid ? data_out : 8'h00;

    always_comb begin
        state_nxt     = state;
        remaining_nxt = remaining;
        wait_cnt_nxt  = wait_cnt;
        read_enb      = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (vld_out) begin
                    if (RD_DELAY > 0) begin
                        state_nxt    = S_WAIT;
                        wait_cnt_nxt = WAIT_LOAD;
                    end else begin
                        state_nxt = S_HDR;
                    end
                end
            end
            S_WAIT: begin
                if (wait_cnt == 5'd0) begin
                    state_nxt = S_HDR;
                end else begin
                    wait_cnt_nxt = wait_cnt - 5'd1;
                end
            end
            S_HDR: begin
                if (vld_out && ready) begin
                    read_enb  = 1'b1;
                    state_nxt = S_HDR_CAP;
                end
            end
            S_HDR_CAP: begin
                remaining_nxt = hdr_reads(data_out[LEN_MSB:LEN_LSB]);
                state_nxt     = S_PAYLOAD;
            end
            S_PAYLOAD: begin
                if (vld_out && ready && (remaining != 7'd0)) begin
                    read_enb      = 1'b1;
                    remaining_nxt = remaining - 7'd1;
                    if (remaining == 7'd1) begin
                        state_nxt = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
        // The FIFO is being emptied under us: issue nothing more.
        if (flush) begin
            state_nxt     = S_IDLE;
            remaining_nxt = 7'd0;
            read_enb      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= S_IDLE;
            remaining <= 7'd0;
            wait_cnt  <= 5'd0;
        end else begin
            state     <= state_nxt;
            remaining <= remaining_nxt;
            wait_cnt  <= wait_cnt_nxt;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pkt_valid <= 1'b0;
            pkt_sop   <= 1'b0;
            pkt_eop   <= 1'b0;
            pkt_abort <= 1'b0;
            pkt_count <= 8'd0;
        end else begin
            pkt_valid <= read_enb;
            pkt_sop   <= read_enb && (state == S_HDR);
            pkt_eop   <= read_enb && (state == S_PAYLOAD)
                         && (remaining == 7'd1);
            // A flush landing on the parity byte still completes the packet.
            pkt_abort <= flush && !pkt_eop;
            if (pkt_eop) begin
                pkt_count <= pkt_count + 8'd1;
            end
        end
    end

`ifdef ROUTER_RD_PARITY_CHECK_EN
    router_rd_parity u_parity (
        .clk        (clk),
        .resetn     (resetn),
        .sop        (pkt_sop),
        .byte_vld   (pkt_valid && !pkt_eop),
        .eop        (pkt_eop),
        .data       (data_out),
        .parity_err (parity_err)
    );
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_router_out_reader.sv
// tb_router_out_reader: FIFO model plus packet-level scoreboard
// driving router_out_reader with table, directed and random traffic.
module tb_router_out_reader;
    import router_pkg::*;

`ifdef ROUTER_RD_PARITY_CHECK_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    typedef struct {
        logic [7:0] d;
        bit         sop;
        bit         eop;
        bit         perr;
    } exp_t;

    typedef struct {
        int         len;
        logic [7:0] base;
        bit         bad;
        int         stall_after;
        int         stall_cyc;
        bit         vgap;
        int         exp_bytes;
        int         exp_perr;
    } vec_t;

    logic       clk = 1'b0;
    logic       resetn;
    logic       vld_out;
    logic [7:0] data_out = 8'h00;
    logic       soft_reset;
    logic       ready;
    logic       read_enb;
    logic [7:0] pkt_data;
    logic       pkt_valid, pkt_sop, pkt_eop;
    logic       parity_err, pkt_abort, busy;
    logic [7:0] pkt_count;

    logic       vld5, soft5, ready5;
    logic [7:0] data5 = 8'h00;
    logic       read5, pv5, sop5, eop5, perr5, abort5, busy5;
    logic [7:0] pdata5, cnt5;

    logic [7:0] fifo[$];
    exp_t       expq[$];
    vec_t       tbl[6];

    int  n_chk = 0;
    int  n_fail = 0;
    int  n_bytes = 0;
    int  n_perr = 0;
    int  n_abort = 0;
    int  exp_count = 0;
    int  starve = 0;
    int  max_starve = 0;
    bit  gate = 1'b1;
    bit  rand_ready = 1'b0;

    router_out_reader #(.RD_DELAY(0)) dut (
        .clk(clk), .resetn(resetn), .vld_out(vld_out),
        .data_out(data_out), .soft_reset(soft_reset), .ready(ready),
        .read_enb(read_enb), .pkt_data(pkt_data), .pkt_valid(pkt_valid),
        .pkt_sop(pkt_sop), .pkt_eop(pkt_eop), .parity_err(parity_err),
        .pkt_abort(pkt_abort), .pkt_count(pkt_count), .busy(busy)
    );

    router_out_reader #(.RD_DELAY(5)) dut5 (
        .clk(clk), .resetn(resetn), .vld_out(vld5),
        .data_out(data5), .soft_reset(soft5), .ready(ready5),
        .read_enb(read5), .pkt_data(pdata5), .pkt_valid(pv5),
        .pkt_sop(sop5), .pkt_eop(eop5), .parity_err(perr5),
        .pkt_abort(abort5), .pkt_count(cnt5), .busy(busy5)
    );

    always #5 clk = ~clk;

    // Output FIFO model: flushed by soft_reset, read data next cycle.
    always @(posedge clk) begin
        if (soft_reset) begin
            fifo.delete();
        end else if (read_enb && fifo.size() != 0) begin
            data_out <= fifo.pop_front();
        end
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic put(input logic [7:0] b, input bit sop, input bit eop,
                       input bit perr);
        exp_t e;
        e.d = b; e.sop = sop; e.eop = eop; e.perr = perr;
        fifo.push_back(b);
        expq.push_back(e);
    endtask

    task automatic push_pkt(input int len, input logic [7:0] base,
                            input bit bad, input logic [ADDR_W-1:0] addr,
                            input bit rnd);
        logic [7:0] hdr, b, par;
        logic [5:0] l6;
        l6  = 6'(len);
        hdr = {l6, addr};
        par = hdr;
        put(hdr, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < len; i++) begin
            b = rnd ? 8'($urandom) : 8'(base * (i + 1));
            par ^= b;
            put(b, 1'b0, 1'b0, 1'b0);
        end
        if (bad) par = ~par;
        put(par, 1'b0, 1'b1, bad && PAR_EN);
        exp_count++;
    endtask

    task automatic monitor();
        exp_t e;
        if (read_enb) check("rd_gate", {vld_out, ready, soft_reset}, 3'b110);
        if (pkt_abort) n_abort++;
        if (parity_err) n_perr++;
        if (resetn && vld_out && ready && !read_enb) starve++;
        else starve = 0;
        if (starve > max_starve) max_starve = starve;
        if (pkt_valid) begin
            n_bytes++;
            if (expq.size() == 0) begin
                check("extra_byte", pkt_valid, 0);
            end else begin
                e = expq.pop_front();
                check("byte", {pkt_data, pkt_sop, pkt_eop, parity_err},
                      {e.d, e.sop, e.eop, e.perr});
            end
        end else begin
            check("flags_idle", {pkt_sop, pkt_eop, parity_err}, 0);
        end
    endtask

    task automatic upd();
        vld_out = gate && (fifo.size() != 0);
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        if (rand_ready) ready = ($urandom_range(0, 3) != 0);
        upd();
    endtask

    task automatic wait_done(input string name, input int budget);
        int k = 0;
        while ((fifo.size() != 0 || expq.size() != 0 || busy) && k < budget)
        begin
            tick();
            k++;
        end
        check({name, "_done"}, (k < budget), 1);
    endtask

    initial begin
        int k;
        tbl[0] = '{3,  8'h11, 1'b1, 0, 0, 1'b0, 5,  PAR_EN};
        tbl[1] = '{8,  8'h21, 1'b0, 4, 6, 1'b0, 10, 0};
        tbl[2] = '{10, 8'h07, 1'b0, 3, 4, 1'b1, 12, 0};
        tbl[3] = '{63, 8'h05, 1'b0, 0, 0, 1'b0, 65, 0};
        tbl[4] = '{1,  8'h80, 1'b1, 1, 6, 1'b0, 3,  PAR_EN};
        tbl[5] = '{20, 8'h13, 1'b0, 2, 6, 1'b1, 22, 0};

        resetn = 1'b0; ready = 1'b1; soft_reset = 1'b0;
        vld5 = 1'b0; soft5 = 1'b0; ready5 = 1'b1;
        push_pkt(3, 8'h11, 1'b0, 2'd0, 1'b0);
        upd();
        repeat (3) tick();
        check("reset_outs", {read_enb, pkt_valid, pkt_sop, pkt_eop,
              parity_err, pkt_abort, busy, pkt_count, pkt_data}, 0);
        check("reset_outs5", {read5, pv5, sop5, eop5, perr5, abort5,
              busy5, cnt5, pdata5}, 0);

        // Header 0x0C already waiting when reset lifts.
        resetn = 1'b1;
        k = 0;
        while (!read_enb && k < 10) begin tick(); k++; end
        check("first_rd_lat", k, 1);
        wait_done("pkt0c", 200);
        check("pkt0c_bytes", n_bytes, 5);
        check("pkt0c_perr", n_perr, 0);
        check("pkt0c_count", pkt_count, 1);

        vld5 = 1'b1;
        k = 0;
        while (!read5 && k < 20) begin tick(); k++; end
        check("rd_delay5_lat", k, 6);
        soft5 = 1'b1; vld5 = 1'b0;
        tick();
        soft5 = 1'b0;
        check("abort5", {abort5, busy5}, 2'b10);

        foreach (tbl[i]) begin
            n_bytes = 0; n_perr = 0; n_abort = 0;
            push_pkt(tbl[i].len, tbl[i].base, tbl[i].bad, 2'(i), 1'b0);
            upd();
            if (tbl[i].stall_cyc > 0) begin
                k = 0;
                while (n_bytes < tbl[i].stall_after && k < 500) begin
                    tick(); k++;
                end
                if (tbl[i].vgap) gate = 1'b0;
                else ready = 1'b0;
                upd();
                for (int c = 0; c < tbl[i].stall_cyc; c++) begin
                    tick();
                    check($sformatf("vec%0d_stall_rd", i), read_enb, 0);
                end
                gate = 1'b1; ready = 1'b1;
                upd();
            end
            wait_done($sformatf("vec%0d", i), 2000);
            check($sformatf("vec%0d_bytes", i), n_bytes, tbl[i].exp_bytes);
            check($sformatf("vec%0d_perr", i), n_perr, tbl[i].exp_perr);
            check($sformatf("vec%0d_abort", i), n_abort, 0);
            check($sformatf("vec%0d_count", i), pkt_count, 8'(exp_count));
        end

        // Abort an L=10 packet after its second payload byte.
        n_bytes = 0; n_abort = 0;
        push_pkt(10, 8'h31, 1'b0, 2'd1, 1'b0);
        upd();
        k = 0;
        while (n_bytes < 3 && k < 100) begin tick(); k++; end
        check("sr_reach", n_bytes, 3);
        soft_reset = 1'b1;
        expq.delete();
        exp_count--;
        tick();
        check("sr_abort", {pkt_abort, busy, pkt_valid}, 3'b100);
        soft_reset = 1'b0;
        upd();
        tick();
        check("sr_pulse", pkt_abort, 0);
        check("sr_abort_cnt", n_abort, 1);
        check("sr_count", pkt_count, 8'(exp_count));

        n_abort = 0;
        rand_ready = 1'b1;
        repeat (20) begin
            push_pkt($urandom_range(1, 63), 8'h00,
                     ($urandom_range(0, 3) == 0),
                     2'($urandom), 1'b1);
        end
        upd();
        wait_done("rand", 8000);
        rand_ready = 1'b0; ready = 1'b1;
        check("rand_count", pkt_count, 8'(exp_count));
        check("rand_abort", n_abort, 0);

        resetn = 1'b0;
        fifo.delete(); expq.delete(); exp_count = 0;
        upd();
        tick(); tick();
        check("rst2_count", pkt_count, 0);
        resetn = 1'b1;
        for (int p = 0; p < 255; p++) push_pkt(1, 8'(p), 1'b0, 2'd2, 1'b0);
        upd();
        wait_done("wrap255", 5000);
        check("wrap255_count", pkt_count, 8'd255);
        push_pkt(1, 8'h5a, 1'b0, 2'd3, 1'b0);
        upd();
        wait_done("wrap256", 100);
        check("wrap_zero", pkt_count, 8'd0);

        push_pkt(1, 8'h66, 1'b0, 2'd0, 1'b0);
        upd();
        wait_done("pre_rst", 100);
        check("pre_rst_count", pkt_count, 8'd1);
        n_bytes = 0;
        push_pkt(10, 8'h44, 1'b0, 2'd1, 1'b0);
        upd();
        k = 0;
        while (n_bytes < 3 && k < 100) begin tick(); k++; end
        #2;
        resetn = 1'b0;
        #1;
        check("async_rst", {read_enb, pkt_valid, pkt_sop, pkt_eop,
              parity_err, pkt_abort, busy, pkt_count, pkt_data}, 0);
        fifo.delete(); expq.delete(); exp_count = 0;
        upd();
        tick();
        resetn = 1'b1;
        tick();

        check("max_starve", (max_starve < ROUTER_TIMEOUT), 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/router_out_reader.md
ROUTER_OUT_READER -- requirements
Module: router_out_reader

Interface
REQ-001 SHALL have parameter RD_DELAY, default 0, meaning idle cycles inserted between vld_out rising and the header read (legal 0..20).
REQ-002 SHALL have ports: clk  in  1  single clock, rising edge.
REQ-003 SHALL have ports: resetn  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports: vld_out  in  1  output FIFO non-empty.
REQ-005 SHALL have ports: data_out  in  8  FIFO read data, valid the cycle after read_enb.
REQ-006 SHALL have ports: soft_reset  in  1  FIFO flushed by the router timeout.
REQ-007 SHALL have ports: ready  in  1  sink may accept a byte.
REQ-008 SHALL have ports: read_enb  out  1  FIFO read strobe.
REQ-009 SHALL have ports: pkt_data  out  8, pkt_valid  out  1, pkt_sop  out  1, pkt_eop  out  1  byte stream to sink.
REQ-010 SHALL have ports: parity_err  out  1, pkt_abort  out  1  one-cycle status pulses.
REQ-011 SHALL have ports: pkt_count  out  8  completed packets, wraps 255->0.
REQ-012 SHALL have ports: busy  out  1  high in any state except IDLE.

Function
REQ-013 SHALL use packet format: header [1:0] addr, [7:2] payload length L (1..63); then L payload bytes; then one parity byte equal to the XOR of header and payload.
REQ-014 SHALL implement states IDLE, WAIT, HDR, HDR_CAP, PAYLOAD, DRAIN.
REQ-015 SHALL leave IDLE when vld_out=1: to WAIT if RD_DELAY>0, else to HDR.
REQ-016 SHALL stay in WAIT for exactly RD_DELAY cycles, then go to HDR.
REQ-017 SHALL in HDR assert read_enb for one cycle when vld_out=1 and ready=1, then go to HDR_CAP.
REQ-018 SHALL in HDR_CAP capture data_out as the header, load remaining=L+1, and go to PAYLOAD.
REQ-019 SHALL in PAYLOAD drive read_enb = vld_out & ready & (remaining!=0), decrementing remaining on each read.
REQ-020 SHALL go from PAYLOAD to DRAIN on the issue of the last read, and from DRAIN to IDLE one cycle later.
REQ-021 SHALL register the stream: pkt_valid = read_enb delayed by one cycle, with pkt_data = data_out in that cycle.
REQ-022 SHALL pulse pkt_sop with the header byte and pkt_eop with the parity byte.
REQ-023 SHALL gate reads with ready only; the sink SHALL accept every byte that has pkt_valid=1.
REQ-024 SHALL, when vld_out falls mid-packet, stall with no read and no abort, and resume when vld_out returns.
REQ-025 SHALL, when soft_reset=1 in any non-IDLE state, go to IDLE next cycle, pulse pkt_abort, drop any in-flight pkt_valid, and leave pkt_count unchanged.
REQ-026 SHALL increment pkt_count in the pkt_eop cycle.
REQ-027 SHALL, if soft_reset coincides with pkt_eop, treat the packet as complete with no abort.
REQ-028 SHALL never hold vld_out=1 unread for 29 or more consecutive cycles while ready=1.

Reset
REQ-029 SHALL, with resetn=0, asynchronously force state=IDLE, remaining=0, read_enb=0, pkt_valid=pkt_sop=pkt_eop=0, parity_err=pkt_abort=0, pkt_count=0, pkt_data=0, busy=0.
REQ-030 SHALL, on reset deassertion, first read no earlier than the second rising clk edge.

Configuration
REQ-031 SHALL, with ROUTER_RD_PARITY_CHECK_EN defined, accumulate a running XOR over header and payload and pulse parity_err with pkt_eop when the result does not equal the parity byte.
REQ-032 SHALL, without ROUTER_RD_PARITY_CHECK_EN, still consume and forward the parity byte, and tie parity_err to 0.

Structure
REQ-033 SHALL take the state enum, header field positions (LEN_MSB=7, LEN_LSB=2, ADDR_W=2) and ROUTER_TIMEOUT=29 from the shared package router_pkg.
REQ-034 SHALL place the XOR accumulator and compare in one sub-module, router_rd_parity, instantiated only under ROUTER_RD_PARITY_CHECK_EN.

Verification
REQ-035 SHALL test: header 0x0C (L=3, addr 0), payload 11,22,33, parity 0x0C^0x11^0x22^0x33 -> 5 pkt_valid bytes, sop on 0x0C, eop on parity, parity_err=0, pkt_count=1.
REQ-036 SHALL test: same packet with parity byte flipped -> parity_err pulses with eop (macro on); parity_err stays 0 (macro off).
REQ-037 SHALL test: ready low for 6 cycles mid-payload -> read_enb low for those cycles, no bytes lost, no abort.
REQ-038 SHALL test: soft_reset asserted after the 2nd payload byte of an L=10 packet -> pkt_abort pulse, IDLE next cycle, pkt_count unchanged.
REQ-039 SHALL test: RD_DELAY=5 -> first read_enb exactly 6 cycles after vld_out rises.
REQ-040 SHALL test: 256 back-to-back L=1 packets -> pkt_count wraps to 0, and resetn pulsed mid-packet clears all outputs immediately.
